encoder_8to3_seq: RTL and testbench
===================================

Name: encoder_8to3_seq

Overview:
- Sequential 8-to-3 encoder; the inverse of the team's 3x8 decoder.
- Captures requests on 8 one-hot-style lines into a pending register and presents one 3-bit code at a time on a valid/ready handshake.
- The code is exactly the select value that makes the 3x8 decoder assert that line, so encoder output can drive the decoder directly.
- Simultaneous requests are serialised, never lost.

Parameters:
RR, 0, arbitration mode: 0 = fixed priority (line 1 highest), 1 = round-robin starting after the last granted line

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  request capture enable; 0 blocks new captures, draining continues
d  input  8  request lines; d[k-1] = line k (decoder output z_k)
ready  input  1  consumer accepts code this cycle when valid=1
code  output  3  encoded line, {s1,s2,s3} order, code = 7-(k-1) = ~(k-1)[2:0]
valid  output  1  code is presented
more  output  1  pending set (excluding presented line) is nonzero
busy  output  1  valid | (pending != 0)

Behaviour:
- Reset (async, immediate):
  - pending=8'h00, code=3'b000, valid=0, more=0, busy=0.
  - FSM=IDLE; round-robin pointer=7, so the first search starts at line 1.
- Code mapping:
  - line 1 -> 3'b111, line 2 -> 3'b110, line 3 -> 3'b101, line 4 -> 3'b100.
  - line 5 -> 3'b011, line 6 -> 3'b010, line 7 -> 3'b001, line 8 -> 3'b000.
- Capture:
  - Each edge: pending <= (pending & ~clr) | (d & {8{enable}}).
  - clr is the one-hot of the line loaded this cycle.
  - Level-sensitive: a line held high re-requests every cycle.
- Selection:
  - RR=0: lowest-index set bit of the candidate set.
  - RR=1: first set bit at index ptr+1, ptr+2, ... wrapping 7->0. ptr updates to the granted index on each load.
- Candidate set is pending only (registered). d affects selection one cycle later.
- FSM:
  - IDLE: valid=0. If pending!=0: load code of the selected line, set clr, valid<=1, go to PRESENT. Otherwise stay.
  - PRESENT: code and valid held stable while ready=0.
  - PRESENT with ready=1 and pending!=0: load the next line the same edge (back-to-back, no bubble), stay PRESENT.
  - PRESENT with ready=1 and pending=0: valid<=0, code holds its last value, go to IDLE.
- Latency:
  - d high at edge N -> pending bit at N -> valid/code at N+1, i.e. 2 edges from IDLE.
  - Sustained throughput: 1 code per cycle with ready=1.
- Boundary conditions:
  - Set and clear of the same bit in one cycle: set wins, so the line is re-presented later.
  - The presented line's pending bit clears at load. A re-request while it is being presented queues a new instance.
  - enable=0 with pending nonzero: existing requests are still drained.
  - all 8 lines set: codes emitted in priority/RR order over 8 handshakes.
  - ready=1 while valid=0: ignored.
  - reset asserted mid-transfer: all state cleared immediately, presented code discarded, no partial output after release.
- more is registered alongside code: more = ((pending_next & ~clr) != 0).
- busy is combinational from registered state only.

Decomposition:
- Package encoder_8to3_pkg:
  - N_LINES=8, CODE_W=3.
  - State enum {IDLE, PRESENT}.
  - Function line_to_code(idx) = ~idx[2:0].
- Sub-module prio_pick8:
  - Combinational 8-bit picker.
  - Inputs: req[7:0], start[2:0], rr.
  - Outputs: gnt_onehot[7:0], gnt_idx[2:0], any.
  - Instantiated once.

Test Plan:
- Reset/idle: assert reset mid-operation with valid=1 -> valid, code, more and busy all 0 immediately; after release with d=0, valid stays 0.
- Single request: d=8'h01 for one cycle, ready=1 -> valid high 2 edges later with code=3'b111 for exactly 1 cycle, more=0.
- Round trip: d=8'h80, enable=1 -> code=3'b000. Feeding code into the 3x8 decoder asserts z8 only.
- Multi-request, RR=0:
  - d=8'h25 for one cycle, ready=1 -> codes 3'b111, 3'b101, 3'b010 on consecutive cycles.
  - more=1,1,0 respectively; then valid=0.
- Backpressure plus set-wins:
  - d=8'h02, ready=0 for 5 cycles -> code=3'b110 held stable, valid=1.
  - Pulse d=8'h02 again while presented, then ready=1 -> 3'b110 presented twice.
- RR=1 with d held at 8'h81:
  - Alternating codes 3'b111, 3'b000, 3'b111, 3'b000.
  - With RR=0 under the same stimulus: 3'b111 repeats and line 8 starves.
  - enable=0 mid-stream: queued lines drain, then valid drops.

Source files
------------

// File: rtl/encoder_8to3_seq_pkg.sv
// encoder_8to3_pkg: shared widths, FSM states and line-to-code mapping for the sequential 8-to-3 encoder
package encoder_8to3_pkg;
  localparam int N_LINES = 8;
  localparam int CODE_W = 3;
  typedef enum logic {IDLE, PRESENT} state_t;
  function automatic logic [CODE_W-1:0] line_to_code(input logic [CODE_W-1:0] idx);
    return ~idx;
  endfunction
endpackage

// File: rtl/encoder_8to3_seq_if.sv
// encoder_8to3_seq_if: request lines plus valid/ready code handshake of the sequential encoder
interface encoder_8to3_seq_if;
  import encoder_8to3_pkg::*;
  logic enable;
  logic [N_LINES-1:0] d;
  logic ready;
  logic [CODE_W-1:0] code;
  logic valid;
  logic more;
  logic busy;
  modport master (output enable, d, ready, input code, valid, more, busy);
  modport slave (input enable, d, ready, output code, valid, more, busy);
endinterface

// File: rtl/encoder_8to3_seq_prio_pick8.sv
// prio_pick8: combinational 8-bit picker, lowest set bit or first set bit at/after start when rr=1
module prio_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] start,
  input  logic       rr,
  output logic [7:0] gnt_onehot,
  output logic [2:0] gnt_idx,
  output logic       any
);
  logic [2:0] eff, off;
  logic [7:0] rot;
  always_comb begin
    eff = rr ? start : 3'd0;
    rot = '0;
    off = '0;
    for (int i = 0; i < 8; i++) rot[i] = req[3'(i) + eff];
    for (int i = 7; i >= 0; i--) if (rot[i]) off = 3'(i);
    any = |req;
    gnt_idx = off + eff;
    gnt_onehot = any ? 8'd1 << gnt_idx : 8'd0;
  end
endmodule

// File: rtl/encoder_8to3_seq.sv
// encoder_8to3_seq: captures request lines into a pending set and serialises them as decoder select codes
module encoder_8to3_seq
  import encoder_8to3_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input logic clk,
  input logic reset,
  encoder_8to3_seq_if.slave bus
);
  state_t state_q, state_d;
  logic [N_LINES-1:0] pending_q, pending_d, clr, gnt_onehot;
  logic [CODE_W-1:0] code_q, code_d, ptr_q, ptr_d, gnt_idx;
  logic more_q, more_d, any, load;
  prio_pick8 u_pick (
    .req(pending_q),
    .start(ptr_q + 3'd1),
    .rr(RR),
    .gnt_onehot(gnt_onehot),
    .gnt_idx(gnt_idx),
    .any(any)
  );
  always_comb begin
    load = any && (state_q == IDLE || bus.ready);
    clr = load ? gnt_onehot : '0;
    pending_d = (pending_q & ~clr) | (bus.d & {N_LINES{bus.enable}});
    state_d = load ? PRESENT : (state_q == PRESENT && bus.ready) ? IDLE : state_q;
    code_d = load ? line_to_code(gnt_idx) : code_q;
    ptr_d = load ? gnt_idx : ptr_q;
    more_d = state_d == PRESENT && |(pending_d & ~clr);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pending_q <= '0;
      code_q <= '0;
      ptr_q <= 3'd7;
      more_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      code_q <= code_d;
      ptr_q <= ptr_d;
      more_q <= more_d;
    end
  end
  assign bus.code = code_q;
  assign bus.valid = state_q == PRESENT;
  assign bus.more = more_q;
  assign bus.busy = state_q == PRESENT || pending_q != '0;
endmodule

// File: tb/tb_encoder_8to3_seq.sv
// tb_encoder_8to3_seq: random and directed checks of both arbitration modes against a behavioural model
module tb_encoder_8to3_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic rdy = 1'b1;
  logic [7:0] d = 8'h00;
  int pass_cnt = 0;
  int total_cnt = 0;
  int qc0[$], qc1[$], qm0[$];
  logic [7:0] m_pend[2] = '{8'h00, 8'h00};
  int m_code[2] = '{0, 0};
  int m_ptr[2] = '{7, 7};
  bit m_valid[2] = '{1'b0, 1'b0};
  bit m_more[2] = '{1'b0, 1'b0};
  always #5 clk = ~clk;
  encoder_8to3_seq_if bus0();
  encoder_8to3_seq_if bus1();
  assign bus0.enable = en;
  assign bus0.d = d;
  assign bus0.ready = rdy;
  assign bus1.enable = en;
  assign bus1.d = d;
  assign bus1.ready = rdy;
  encoder_8to3_seq #(.RR(1'b0)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
  encoder_8to3_seq #(.RR(1'b1)) dut1 (.clk(clk), .reset(rst), .bus(bus1));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic int pick(input int rr, input logic [7:0] p, input int ptr);
    int c;
    for (int k = 1; k <= 8; k++) begin
      c = rr != 0 ? (ptr + k) % 8 : k - 1;
      if (p[c]) return c;
    end
    return -1;
  endfunction
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clear_q();
    qc0.delete();
    qc1.delete();
    qm0.delete();
  endtask
  function automatic int at(input int q[$], input int i);
    return q.size() > i ? q[i] : -1;
  endfunction
  initial begin
    logic [7:0] dm, np, msk;
    int idx;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int m = 0; m < 2; m++) begin
          m_pend[m] = 8'h00;
          m_code[m] = 0;
          m_ptr[m] = 7;
          m_valid[m] = 1'b0;
          m_more[m] = 1'b0;
        end
      end
      chk("m0 valid", 32'(bus0.valid), 32'(m_valid[0]));
      chk("m0 code", 32'(bus0.code), 32'(m_code[0]));
      chk("m0 more", 32'(bus0.more), 32'(m_more[0]));
      chk("m0 busy", 32'(bus0.busy), 32'(m_valid[0] || m_pend[0] != 0));
      chk("m1 valid", 32'(bus1.valid), 32'(m_valid[1]));
      chk("m1 code", 32'(bus1.code), 32'(m_code[1]));
      chk("m1 more", 32'(bus1.more), 32'(m_more[1]));
      chk("m1 busy", 32'(bus1.busy), 32'(m_valid[1] || m_pend[1] != 0));
      if (bus0.valid && rdy) begin
        qc0.push_back(int'(bus0.code));
        qm0.push_back(int'(bus0.more));
      end
      if (bus1.valid && rdy) qc1.push_back(int'(bus1.code));
      if (!rst) begin
        dm = en ? d : 8'h00;
        for (int m = 0; m < 2; m++) begin
          if (m_pend[m] != 0 && (!m_valid[m] || rdy)) begin
            idx = pick(m, m_pend[m], m_ptr[m]);
            msk = 8'd1 << idx;
            m_code[m] = 7 - idx;
            m_ptr[m] = idx;
            np = (m_pend[m] & ~msk) | dm;
            m_valid[m] = 1'b1;
            m_more[m] = (np & ~msk) != 0;
          end else begin
            if (m_valid[m] && rdy) m_valid[m] = 1'b0;
            np = m_pend[m] | dm;
            m_more[m] = m_valid[m] && np != 0;
          end
          m_pend[m] = np;
        end
      end
    end
  end
  initial begin
    chk("pick rr wrap", 32'(pick(1, 8'h81, 0)), 32'd7);
    chk("pick rr from 7", 32'(pick(1, 8'h81, 7)), 32'd0);
    chk("pick rr mid", 32'(pick(1, 8'h25, 2)), 32'd5);
    chk("pick fixed", 32'(pick(0, 8'h24, 7)), 32'd2);
    cyc(3);
    chk("rst valid", 32'(bus0.valid), 32'd0);
    chk("rst busy", 32'(bus0.busy), 32'd0);
    rst = 1'b0;
    cyc(2);
    clear_q();
    d = 8'h01;
    cyc(1);
    d = 8'h00;
    cyc(5);
    chk("single count", 32'(qc0.size()), 32'd1);
    chk("single code", 32'(at(qc0, 0)), 32'd7);
    chk("single more", 32'(at(qm0, 0)), 32'd0);
    clear_q();
    d = 8'h25;
    cyc(1);
    d = 8'h00;
    cyc(6);
    chk("multi count", 32'(qc0.size()), 32'd3);
    chk("multi code0", 32'(at(qc0, 0)), 32'd7);
    chk("multi code1", 32'(at(qc0, 1)), 32'd5);
    chk("multi code2", 32'(at(qc0, 2)), 32'd2);
    chk("multi more0", 32'(at(qm0, 0)), 32'd1);
    chk("multi more1", 32'(at(qm0, 1)), 32'd1);
    chk("multi more2", 32'(at(qm0, 2)), 32'd0);
    clear_q();
    d = 8'h80;
    cyc(1);
    d = 8'h00;
    cyc(4);
    chk("line8 code", 32'(at(qc0, 0)), 32'd0);
    chk("decoder z", 32'(8'd1 << (7 - at(qc0, 0))), 32'h80);
    rdy = 1'b0;
    d = 8'h02;
    cyc(1);
    d = 8'h00;
    cyc(5);
    chk("hold valid", 32'(bus0.valid), 32'd1);
    chk("hold code", 32'(bus0.code), 32'd6);
    d = 8'h02;
    cyc(1);
    d = 8'h00;
    chk("hold code again", 32'(bus0.code), 32'd6);
    clear_q();
    rdy = 1'b1;
    cyc(5);
    chk("setwins count", 32'(qc0.size()), 32'd2);
    chk("setwins code0", 32'(at(qc0, 0)), 32'd6);
    chk("setwins code1", 32'(at(qc0, 1)), 32'd6);
    rdy = 1'b0;
    d = 8'h05;
    cyc(1);
    d = 8'h00;
    cyc(2);
    chk("pre-reset valid", 32'(bus0.valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async rst valid", 32'(bus0.valid), 32'd0);
    chk("async rst code", 32'(bus0.code), 32'd0);
    chk("async rst more", 32'(bus0.more), 32'd0);
    chk("async rst busy", 32'(bus0.busy), 32'd0);
    cyc(2);
    rst = 1'b0;
    rdy = 1'b1;
    clear_q();
    cyc(4);
    chk("post-rst count", 32'(qc0.size()), 32'd0);
    chk("post-rst valid", 32'(bus0.valid), 32'd0);
    clear_q();
    d = 8'h81;
    cyc(8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr code%0d", i), 32'(at(qc1, i)), i % 2 == 0 ? 32'd7 : 32'd0);
      chk($sformatf("fixed starve%0d", i), 32'(at(qc0, i)), 32'd7);
    end
    clear_q();
    en = 1'b0;
    cyc(5);
    chk("drain fixed last", 32'(qc0.size() > 0 ? qc0[qc0.size()-1] : -1), 32'd0);
    chk("drain fixed valid", 32'(bus0.valid), 32'd0);
    chk("drain rr valid", 32'(bus1.valid), 32'd0);
    chk("drain rr busy", 32'(bus1.busy), 32'd0);
    d = 8'h00;
    en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      d = $urandom_range(0, 2) == 0 ? 8'($urandom) : 8'h00;
      en = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 2) != 0;
      rst = $urandom_range(0, 99) == 0;
      cyc(1);
    end
    rst = 1'b0;
    d = 8'h00;
    rdy = 1'b1;
    cyc(12);
    chk("final idle", 32'(bus0.busy | bus1.busy), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
